// File: rtl/stamp_capture.sv
// rtl/stamp_capture.sv - event-pin timestamp capture into a FWFT FIFO with a valid/ready readout
module stamp_capture #(
    parameter int TIMESTAMP_WIDTH = 64,
    parameter int FIFO_ADDR_BITS  = 4
) (
    input  logic                       axi_aclk,
    input  logic                       axi_resetn,
    input  logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
    input  logic                       event_in,
    input  logic                       capture_enable,
    input  logic [1:0]                 capture_edge,
    input  logic                       clear,
    output logic [TIMESTAMP_WIDTH-1:0] cap_tdata,
    output logic                       cap_tvalid,
    input  logic                       cap_tready,
    output logic [FIFO_ADDR_BITS:0]    cap_count,
    output logic [31:0]                drop_count
);

    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam logic [FIFO_ADDR_BITS:0] FULL_COUNT = (FIFO_ADDR_BITS+1)'(DEPTH);
    localparam logic [FIFO_ADDR_BITS:0] ONE_COUNT  = (FIFO_ADDR_BITS+1)'(1);

    logic                       s1, s2, s3;
    logic                       rise_q, fall_q;
    logic [1:0]                 arm_cnt;
    logic                       armed;

    logic [TIMESTAMP_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0]  wr_ptr, rd_ptr, rd_next;
    logic [FIFO_ADDR_BITS:0]    count;
    logic [TIMESTAMP_WIDTH-1:0] head_q;

    logic                       sel_edge, evt, full, pop, push, drop;

    assign armed = (arm_cnt == 2'd3);

    // Two-flop synchroniser, history flop, arm counter and registered edge pulses
    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            arm_cnt <= 2'd0;
        end else begin
            s1     <= event_in;
            s2     <= s1;
            s3     <= s2;
            // Gating with armed stops a pin already high at reset release from looking like an edge
            rise_q <= armed & s2 & ~s3;
            fall_q <= armed & ~s2 & s3;
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
        end
    end

    // Edge selection and FIFO push/pop/drop decisions for the current cycle
    always_comb begin
        sel_edge = rise_q;
        case (capture_edge)
            2'b01:   sel_edge = fall_q;
            2'b10:   sel_edge = rise_q | fall_q;
            default: sel_edge = rise_q;
        endcase
        evt     = capture_enable & sel_edge;
        full    = (count == FULL_COUNT);
        pop     = (count != '0) & cap_tready;
        // A full FIFO still accepts an entry when the head leaves in the same cycle
        push    = evt & (~full | pop);
        drop    = evt & full & ~pop;
        rd_next = rd_ptr + 1'b1;
    end

    // Pointers, occupancy, registered head and drop counter
    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_q     <= '0;
            drop_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // Head advances only on a pop; a push into an empty (or emptying) FIFO bypasses the RAM
            if (pop) begin
                if (count > ONE_COUNT) begin
                    head_q <= mem[rd_next];
                end else if (push) begin
                    head_q <= stamp_counter;
                end
            end else if (push && count == '0) begin
                head_q <= stamp_counter;
            end
            if (drop && drop_count != 32'hFFFF_FFFF) begin
                drop_count <= drop_count + 32'd1;
            end
        end
    end

    // Distributed RAM write port; contents need no reset since occupancy governs validity
    always_ff @(posedge axi_aclk) begin
        if (axi_resetn && !clear && push) begin
            mem[wr_ptr] <= stamp_counter;
        end
    end

    assign cap_tdata  = head_q;
    assign cap_tvalid = (count != '0);
    assign cap_count  = count;

endmodule

// File: doc/stamp_capture.md
Name: stamp_capture

Overview:
- Reader side of the free-running timestamp counter.
- Samples the 64-bit stamp_counter bus whenever a selected edge occurs on an external asynchronous event pin (e.g. PPS-in, trigger).
- Queues each captured timestamp in a small first-word-fall-through FIFO.
- Presents the FIFO on a valid/ready stream for the register/DMA path.
- Sits in the timestamp pcore next to the counter, in the same axi_aclk domain.

Parameters:
- TIMESTAMP_WIDTH, 64: width of stamp_counter and of each captured entry.
- FIFO_ADDR_BITS, 4: FIFO depth = 2**FIFO_ADDR_BITS entries (16).

Ports:
- axi_aclk  in  1  sole clock.
- axi_resetn  in  1  synchronous, active-low reset.
- stamp_counter  in  TIMESTAMP_WIDTH  current time from the timestamp counter, axi_aclk domain.
- event_in  in  1  asynchronous event pin.
- capture_enable  in  1  1 = edges are captured; 0 = edges are ignored.
- capture_edge  in  2  edge select: 00 = rising, 01 = falling, 10 = both, 11 = rising.
- clear  in  1  flush the FIFO and zero drop_count.
- cap_tdata  out  TIMESTAMP_WIDTH  FIFO head entry.
- cap_tvalid  out  1  FIFO non-empty.
- cap_tready  in  1  consumer accepts the head entry.
- cap_count  out  FIFO_ADDR_BITS+1  current occupancy, 0..2**FIFO_ADDR_BITS.
- drop_count  out  32  saturating count of edges lost because the FIFO was full.

Behaviour:
- Reset (axi_resetn=0 at a clock edge):
  - All outputs go to 0.
  - FIFO pointers and occupancy go to 0.
  - Synchroniser and edge flops go to 0.
  - Arm counter goes to 0.
- Synchroniser:
  - Two flops (s1, s2), then a history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- Arming:
  - After reset, edge detection is suppressed until 3 clock cycles have elapsed (2-bit arm counter saturates at 3).
  - This prevents a spurious edge when event_in is already high at reset release.
- Event:
  - event = armed & capture_enable & (selected rise/fall per capture_edge).
  - Latency from the event_in transition to the event cycle is 3 clocks; the ±1 cycle uncertainty from async sampling is accepted.
- Captured value: stamp_counter as sampled in the event cycle D.
- Push and pop:
  - Push occurs at the end of cycle D.
  - If the FIFO was empty, cap_tvalid=1 and cap_tdata=captured value in cycle D+1.
  - No same-cycle bypass.
  - Pop occurs when cap_tvalid & cap_tready. The next entry (or empty) is visible the following cycle.
- cap_count updates:
  - +1 on a push without a pop.
  - −1 on a pop without a push.
  - Unchanged on both or neither.
- Full FIFO:
  - event with a simultaneous pop: the push is accepted and occupancy stays full.
  - event without a pop: the entry is dropped and drop_count increments.
  - drop_count saturates at 0xFFFFFFFF.
- Empty FIFO: cap_tready is ignored. cap_tdata is unspecified while cap_tvalid=0 and checkers must ignore it.
- capture_enable=0:
  - Edges are neither stored nor counted as drops.
  - Readout continues normally.
  - The synchroniser keeps running, so re-enabling does not create a false edge.
- clear=1:
  - Priority below reset and above push/pop.
  - Next cycle: occupancy 0, cap_tvalid 0, drop_count 0.
  - Any event or pop in the same cycle is discarded.
  - The synchroniser and arm counter are unaffected.
- Wrap-around:
  - Pointers wrap modulo the depth.
  - Full/empty are distinguished by occupancy, not pointer equality.
- Storage: RAM inferred as distributed memory with a registered head. Write and read on the same address in the same cycle return the old head; the head only ever advances after a pop.
- Reset mid-operation: all contents are lost, with no partial pop.

Test Plan:
- Reset released with event_in held high, capture_edge=00 -> no entry is ever pushed; cap_count stays 0.
- stamp_counter ramps +32/cycle; event_in rises at cycle 100 (sampled) -> cap_tvalid goes high at cycle 104; cap_tdata = stamp_counter value at cycle 103; cap_count=1.
- capture_edge=10, cap_tready=0, 20 toggles on event_in -> cap_count=16, drop_count=4, entries are in-order timestamps of the first 16 edges. Then cap_tready=1 -> 16 consecutive pops, then cap_tvalid=0.
- FIFO full, event coincides with a pop -> cap_count stays 16, drop_count unchanged, the new entry appears last.
- capture_enable=0 during 3 rising edges, then 1 -> no entries, drop_count 0; the next real edge is captured.
- clear pulsed in the same cycle as an event with 5 entries queued and drop_count=7 -> next cycle cap_count=0, cap_tvalid=0, drop_count=0; that event is not stored.
